// File: rtl/md_pkg.sv
// md_pkg: shared constants and state type for the MP3 data FIFO pacing engine.
package md_pkg;
  localparam int BYTE_CLKS_FULL = 18;
  localparam int BYTE_CLKS_HALF = 34;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} md_state_e;
endpackage

// File: rtl/md_fifo_if.sv
// md_fifo_if: Z80-side push/flush signals, DREQ and serializer outputs of md_fifo.
interface md_fifo_if #(parameter int DEPTH_LOG2 = 4);
  logic [7:0] wr_data;
  logic wr_stb;
  logic flush;
  logic halfspeed;
  logic md_dreq;
  logic [7:0] md_din;
  logic md_start;
  logic empty;
  logic full;
  logic [DEPTH_LOG2:0] level;
  logic ovf;
  modport master (output wr_data, wr_stb, flush, halfspeed, md_dreq,
                  input md_din, md_start, empty, full, level, ovf);
  modport slave (input wr_data, wr_stb, flush, halfspeed, md_dreq,
                 output md_din, md_start, empty, full, level, ovf);
endinterface

// File: rtl/md_fifo_mem.sv
// md_fifo_mem: circular byte array with wrapping read/write pointers and combinational head read.
module md_fifo_mem #(parameter int DEPTH_LOG2 = 4) (
  input  logic       cpu_clock,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       clr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] head_o
);
  logic [7:0] mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp_q, rp_q;
  always_ff @(posedge cpu_clock)
    if (push_i) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge cpu_clock or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= clr_i ? '0 : wp_q + DEPTH_LOG2'(push_i);
      rp_q <= clr_i ? '0 : rp_q + DEPTH_LOG2'(pop_i);
    end
  assign head_o = mem_q[rp_q];
endmodule

// File: rtl/md_fifo.sv
// md_fifo: byte FIFO issuing one paced serializer start per byte while DREQ is high.
// Define MD_FIFO_DREQ_SYNC_EN to pass md_dreq through a 2-flop synchronizer.
module md_fifo
  import md_pkg::*;
#(parameter int DEPTH_LOG2 = 4) (
  input logic      cpu_clock,
  input logic      rst_n,
  md_fifo_if.slave bus
);
  localparam int CW = DEPTH_LOG2 + 1;
  logic dreq_s;
`ifdef MD_FIFO_DREQ_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge cpu_clock or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], bus.md_dreq};
  assign dreq_s = sync_q[1];
`else
  assign dreq_s = bus.md_dreq;
`endif
  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0] din_q, din_d, head;
  logic empty_q, full_q, ovf_q, ovf_d, push, pop;
  md_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .cpu_clock(cpu_clock),
    .rst_n(rst_n),
    .push_i(push),
    .pop_i(pop),
    .clr_i(bus.flush),
    .wdata_i(bus.wr_data),
    .head_o(head)
  );
  // The head byte is latched on entry to SEND so md_din is stable while md_start is high.
  always_comb begin
    pop = state_q == SEND && !bus.flush && !empty_q;
    push = bus.wr_stb && !bus.flush && (!full_q || pop);
    state_d = (state_q == IDLE) ? ((!empty_q && dreq_s) ? SEND : IDLE)
            : (state_q == SEND) ? WAIT
            : ((cnt_q == CNT_W'(2)) ? IDLE : WAIT);
    cnt_d = (state_q == SEND) ? (bus.halfspeed ? CNT_W'(BYTE_CLKS_HALF) : CNT_W'(BYTE_CLKS_FULL))
          : (state_q == WAIT) ? cnt_q - CNT_W'(1) : cnt_q;
    din_d = (state_q == IDLE && state_d == SEND) ? head : din_q;
    count_d = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
    ovf_d = !bus.flush && (ovf_q || (bus.wr_stb && full_q && !pop));
  end
  always_ff @(posedge cpu_clock or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      din_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      din_q <= din_d;
      count_q <= count_d;
      empty_q <= count_d == '0;
      full_q <= count_d == CW'(2**DEPTH_LOG2);
      ovf_q <= ovf_d;
    end
  assign bus.md_din = din_q;
  assign bus.md_start = state_q == SEND;
  assign bus.empty = empty_q;
  assign bus.full = full_q;
  assign bus.level = count_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_md_fifo.sv
// tb_md_fifo: random and directed stimulus checked against a queue-and-timestamp model of md_fifo.
module tb_md_fifo;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic cpu_clock = 1'b0;
  logic rst_n = 1'b0;
  md_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();
  md_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (.cpu_clock(cpu_clock), .rst_n(rst_n), .bus(bus));
  always #5 cpu_clock = ~cpu_clock;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic exp_start = 1'b0;
  logic [7:0] exp_din = 8'h00;
  logic m_ovf = 1'b0;
  logic dq1 = 1'b0, dq2 = 1'b0;
  int cyc = 0;
  int free_at = 0;
  int starts = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    q.delete();
    exp_start = 1'b0;
    exp_din = 8'h00;
    m_ovf = 1'b0;
    dq1 = 1'b0;
    dq2 = 1'b0;
    free_at = cyc;
  endtask
  task automatic check_outputs();
    chk("start", 32'(bus.md_start), 32'(exp_start));
    chk("level", 32'(bus.level), 32'(q.size()));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    if (!exp_start) chk("din", 32'(bus.md_din), 32'(exp_din));
  endtask
  // One clock: drive inputs, advance the model across the edge, compare after the edge.
  task automatic step(input logic stb, input logic [7:0] d, input logic fl, input logic hs, input logic dq);
    logic dr, pop, full_m, go;
    logic [7:0] nd;
    bus.wr_stb = stb;
    bus.wr_data = d;
    bus.flush = fl;
    bus.halfspeed = hs;
    bus.md_dreq = dq;
`ifdef MD_FIFO_DREQ_SYNC_EN
    dr = dq2;
`else
    dr = dq;
`endif
    pop = exp_start && !fl && q.size() > 0;
    full_m = q.size() == DEPTH;
    go = !exp_start && cyc >= free_at && q.size() > 0 && dr;
    nd = go ? q[0] : exp_din;
    if (exp_start) free_at = cyc + (hs ? 35 : 19) - 1;
    m_ovf = !fl && (m_ovf || (stb && full_m && !pop));
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (stb && (!full_m || pop)) q.push_back(d);
    end
    exp_start = go;
    exp_din = nd;
    dq2 = dq1;
    dq1 = dq;
    @(posedge cpu_clock);
    cyc++;
    @(negedge cpu_clock);
    if (bus.md_start) starts++;
    check_outputs();
  endtask
  task automatic idle(input int n, input logic hs, input logic dq);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, hs, dq);
  endtask
  int push_pct [4] = '{30, 90, 10, 60};
  int dreq_pct [4] = '{90, 20, 100, 50};
  logic hs_r;
  initial begin
    bus.wr_stb = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush = 1'b0;
    bus.halfspeed = 1'b0;
    bus.md_dreq = 1'b0;
    repeat (3) @(negedge cpu_clock);
    check_outputs();
    rst_n = 1'b1;
    // Three bytes at full speed: starts 19 cycles apart, bytes in order.
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    idle(60, 1'b0, 1'b1);
    chk("three_starts", 32'(starts), 32'd3);
    // Fill with DREQ low, overflow, then drain while pushing into the full FIFO.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    chk("ovf_after_17", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
    // DREQ dropped mid-WAIT with bytes queued.
    idle(5, 1'b0, 1'b0);
    idle(60, 1'b0, 1'b0);
    idle(60, 1'b0, 1'b1);
    // Flush together with a push while ovf is set.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    idle(40, 1'b0, 1'b1);
    // Half speed with a halfspeed toggle mid-WAIT.
    step(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'hA2, 1'b0, 1'b1, 1'b1);
    idle(10, 1'b1, 1'b1);
    idle(90, 1'b0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      hs_r = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(19) == 0) hs_r = ~hs_r;
        step(1'($urandom_range(99) < push_pct[p]), 8'($urandom), 1'($urandom_range(199) == 0),
             hs_r, 1'($urandom_range(99) < dreq_pct[p]));
      end
    end
    // Asynchronous reset in the middle of a WAIT.
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    idle(30, 1'b0, 1'b1);
    step(1'b1, 8'h6B, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h7C, 1'b0, 1'b0, 1'b1);
    idle(6, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_din", 32'(bus.md_din), 32'd0);
    @(negedge cpu_clock);
    rst_n = 1'b1;
    idle(5, 1'b0, 1'b1);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    idle(25, 1'b0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_fifo.md
# md_fifo

Byte FIFO and pacing engine for the MP3 data path. It sits between the Z80 port decoder, which supplies byte-wide write strobes, and the MP3 data SPI serializer, which consumes `md_din` and `md_start`. It buffers bytes written by the Z80 and issues one SPI start per byte, only while the MP3 decoder asserts DREQ. Each start is spaced by the serializer's byte time, so the Z80 no longer polls DREQ for every byte.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes.

Ports:
- `cpu_clock` in 1: system clock, same as the Z80 clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_data` in 8: byte from the port decoder.
- `wr_stb` in 1: one-cycle push strobe.
- `flush` in 1: one-cycle FIFO clear.
- `halfspeed` in 1: serializer speed select. Sampled at each start.
- `md_dreq` in 1: DREQ from the MP3 chip, asynchronous.
- `md_din` out 8: byte presented to the serializer.
- `md_start` out 1: one-cycle start pulse to the serializer.
- `empty` out 1: FIFO holds no bytes.
- `full` out 1: FIFO holds 2^DEPTH_LOG2 bytes.
- `level` out DEPTH_LOG2+1: number of bytes held.
- `ovf` out 1: sticky flag, set when a push is dropped.

## Operation
- Storage is a circular buffer with DEPTH_LOG2-bit read and write pointers and a DEPTH_LOG2+1-bit count.
- Pointers wrap modulo depth. `full` is count == depth; `empty` is count == 0.
- Reset values:
  - `md_din` = 0, `md_start` = 0, `level` = 0, `ovf` = 0.
  - `empty` = 1, `full` = 0.
  - Pointers 0, state IDLE, byte counter 0.
- State machine:
  - IDLE: if !empty and dreq_s == 1, go to SEND.
  - SEND: lasts one cycle. `md_start` = 1; `md_din` <= head byte; pop; load byte counter with BYTE_CLKS_FULL (18) or BYTE_CLKS_HALF (34) according to `halfspeed`. Go to WAIT.
  - WAIT: decrement the counter; at 1, go to IDLE.
- `md_din` holds its value from SEND until the next SEND.
- Push while !full: byte is written at the write pointer and count increments.
- Push while full with no pop in the same cycle: byte is dropped and `ovf` is set.
- Push and pop in the same cycle: both take effect and count is unchanged. This includes the full case, where the push is accepted.
- `flush`:
  - Resets pointers and count, and clears `ovf`.
  - Beats a push in the same cycle; that byte is dropped without setting `ovf`.
  - Beats a pop in the same cycle; that pop is discarded and `md_start` still fires with the already-registered byte.
  - An in-flight WAIT count is not aborted.
- DREQ falling during WAIT: the current byte completes and no new SEND is issued until DREQ is high again.
- A `halfspeed` change mid-byte takes no effect until the next SEND.
- `rst_n` asserted mid-operation forces all reset values immediately. The serializer is reset by the same signal.

## Timing
- Push at edge N: `level` and `empty` reflect it after edge N.
- Empty FIFO, IDLE, dreq_s high, push at edge N: SEND occurs in cycle N+1, so `md_start` is high for exactly one cycle.
- Start-to-start spacing: minimum 19 cycles at full speed, 35 at half speed (1 SEND cycle + the counter).
- `md_start` is never high on two consecutive cycles.
- `level`, `full`, `empty` and `ovf` are registered outputs.

## Configuration
- `MD_FIFO_DREQ_SYNC_EN` defined: `md_dreq` passes through a 2-flop synchronizer, reset to 0, to form dreq_s. This adds 2 cycles of DREQ latency.
- Not defined: dreq_s = `md_dreq` combinationally. Only for benches or when DREQ is already synchronized upstream.

## Structure
- Shared package `md_pkg` holds:
  - BYTE_CLKS_FULL = 18 and BYTE_CLKS_HALF = 34.
  - The state enum IDLE/SEND/WAIT.
  - The byte-counter width (6).
- One sub-module, `md_fifo_mem`: dual-pointer register array, with synchronous write and combinational read of the head. No reset on the array contents.
- The state machine, count and flags live in `md_fifo`.

## Test plan
- Three bytes pushed, DREQ held high, full speed -> `md_start` pulses at cycles 1, 20 and 39 after the first push, with `md_din` = 0x11, 0x22, 0x33 in order. `empty` = 1 after the third start.
- 16 pushes with DREQ low (DEPTH_LOG2=4) -> `full` = 1 and `level` = 16. A 17th push gives `ovf` = 1 and `level` = 16. Raising DREQ then gives 16 starts, with the first byte out equal to the first byte pushed.
- FIFO full, DREQ high, push coincident with a SEND pop -> push accepted, `level` stays 16, `ovf` stays 0.
- DREQ dropped 5 cycles into WAIT with 4 bytes queued -> current byte completes, no further `md_start` until DREQ rises again. With the sync macro defined, resumption is 3 cycles after DREQ rises.
- `halfspeed` = 1 for two queued bytes -> start spacing is 35 cycles. Toggling `halfspeed` mid-WAIT leaves the current spacing unchanged.
- `flush` coincident with a push and `ovf` = 1 -> `level` = 0, `empty` = 1, `ovf` = 0, no further starts. `rst_n` pulsed mid-WAIT -> all outputs return to reset values on the same edge.
